// File: rtl/counter_tx_top.sv
// Cache performance monitor: eight saturating event counters that freeze on
// cpu_done and are then dumped once, MSB byte first, over an 8N1 UART line.
module counter_tx_top #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned CLKS_PER_BIT = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic read_C_L1I,
  input  logic miss_L1I_C,
  input  logic read_C_L1D,
  input  logic write_C_L1D,
  input  logic miss_L1D_C,
  input  logic read_L1_L2,
  input  logic write_L1_L2,
  input  logic miss_L2_L1,
  input  logic cpu_done,
  output logic tx_data
);

  localparam int unsigned NEV = 8;
  localparam int unsigned BPC = CNT_W / 8;
  localparam int unsigned BSW = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int unsigned CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    COUNT,
    LOAD,
    START,
    DATA,
    STOP,
    DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [NEV-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]              clk_q, clk_d;
  logic [2:0]                 bit_q, bit_d;
  logic [2:0]                 evt_q, evt_d;
  logic [BSW-1:0]             bsel_q, bsel_d;
  logic [7:0]                 sh_q, sh_d;
  logic                       tx_q, tx_d;

  logic [NEV-1:0]             ev;
  logic [7:0]                 cur_byte;
  logic                       bit_end;
  logic                       last_byte;
  logic                       stop_end;

  assign ev = {miss_L2_L1, write_L1_L2, read_L1_L2, miss_L1D_C,
               write_C_L1D, read_C_L1D, miss_L1I_C, read_C_L1I};

  assign tx_data   = tx_q;
  assign bit_end   = (clk_q == CW'(CLKS_PER_BIT - 1));
  assign last_byte = (evt_q == 3'(NEV - 1)) && (bsel_q == '0);
  // Between frames the LOAD cycle is the final cycle of the stop bit, so a
  // non-final STOP lasts one cycle less and frames stay back-to-back.
  assign stop_end  = last_byte ? bit_end : (clk_q == CW'(CLKS_PER_BIT - 2));

  // Byte lane select of the counter currently being transmitted.
  always_comb begin
    cur_byte = '0;
    for (int unsigned j = 0; j < BPC; j++) begin
      if (bsel_q == BSW'(j)) cur_byte = cnt_q[evt_q][j*8 +: 8];
    end
  end

  // Next-state logic: counting, freeze, and UART framing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    bit_d   = bit_q;
    evt_d   = evt_q;
    bsel_d  = bsel_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    case (state_q)
      COUNT: begin
        if (cpu_done) begin
          state_d = LOAD;
        end else begin
          for (int unsigned i = 0; i < NEV; i++) begin
            if (ev[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
      LOAD: begin
        sh_d    = cur_byte;
        tx_d    = 1'b0;
        clk_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          clk_d   = '0;
          bit_d   = '0;
          tx_d    = sh_q[0];
          sh_d    = {1'b0, sh_q[7:1]};
          state_d = DATA;
        end else begin
          clk_d = clk_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[0];
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end else begin
          clk_d = clk_q + CW'(1);
        end
      end
      STOP: begin
        if (stop_end) begin
          clk_d = '0;
          if (last_byte) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
            if (bsel_q == '0) begin
              bsel_d = BSW'(BPC - 1);
              evt_d  = evt_q + 3'd1;
            end else begin
              bsel_d = bsel_q - BSW'(1);
            end
          end
        end else begin
          clk_d = clk_q + CW'(1);
        end
      end
      DONE: begin
        tx_d = 1'b1;
      end
      default: begin
        state_d = COUNT;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= COUNT;
      cnt_q   <= '0;
      clk_q   <= '0;
      bit_q   <= '0;
      evt_q   <= '0;
      bsel_q  <= BSW'(BPC - 1);
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      bit_q   <= bit_d;
      evt_q   <= evt_d;
      bsel_q  <= bsel_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_counter_tx_top.sv
// Bench for counter_tx_top: cycle-level line model plus an independent UART
// receiver whose decoded bytes are checked against hand-computed values.
module tb_counter_tx_top;

  localparam int C  = 64;
  localparam int NB = 32;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] ev;
  logic       cpu_done;
  logic       tx_data;

  int total = 0;
  int bad   = 0;

  counter_tx_top #(.CNT_W(32), .CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .read_C_L1I  (ev[0]),
    .miss_L1I_C  (ev[1]),
    .read_C_L1D  (ev[2]),
    .write_C_L1D (ev[3]),
    .miss_L1D_C  (ev[4]),
    .read_L1_L2  (ev[5]),
    .write_L1_L2 (ev[6]),
    .miss_L2_L1  (ev[7]),
    .cpu_done    (cpu_done),
    .tx_data     (tx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mcnt [8];
  logic [7:0]  mbytes [NB];
  bit          mdump;
  int          mt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) mcnt[i] = 32'd0;
      mdump = 1'b0;
      mt    = 0;
    end else if (!mdump) begin
      if (cpu_done) begin
        mdump = 1'b1;
        mt    = 0;
        for (int f = 0; f < NB; f++)
          mbytes[f] = 8'(mcnt[f / 4] >> (8 * (3 - (f % 4))));
      end else begin
        for (int i = 0; i < 8; i++)
          if (ev[i] && mcnt[i] != 32'hFFFF_FFFF) mcnt[i] = mcnt[i] + 32'd1;
      end
    end else begin
      mt = mt + 1;
    end
  end

  // Line level implied by the dump timeline: idle, then 32 frames of 10 bits.
  function automatic logic exp_tx();
    int k, f, bp;
    if (!mdump || mt == 0) return 1'b1;
    k = mt - 1;
    if (k >= NB * 10 * C) return 1'b1;
    f  = k / (10 * C);
    bp = (k % (10 * C)) / C;
    if (bp == 0) return 1'b0;
    if (bp == 9) return 1'b1;
    return mbytes[f][bp - 1];
  endfunction

  always @(negedge clk) check("tx_line", {63'd0, tx_data}, {63'd0, exp_tx()});

  // ---------------- independent UART receiver ----------------
  logic [7:0] rx_q [$];

  task automatic rx_frame(output bit ok, output logic [7:0] d);
    ok = 1'b0;
    d  = '0;
    repeat (C / 2) begin @(negedge clk); if (!rstn) return; end
    for (int b = 0; b < 8; b++) begin
      repeat (C) begin @(negedge clk); if (!rstn) return; end
      d[b] = tx_data;
    end
    repeat (C) begin @(negedge clk); if (!rstn) return; end
    ok = tx_data;
  endtask

  initial begin
    bit         rok;
    logic [7:0] rd;
    forever begin
      @(negedge clk);
      if (rstn && tx_data === 1'b0) begin
        rx_frame(rok, rd);
        if (rok) rx_q.push_back(rd);
      end
    end
  end

  function automatic logic [31:0] rx_word(input int i);
    if (rx_q.size() < 4 * i + 4) return 32'hDEAD_BEEF;
    return {rx_q[4*i], rx_q[4*i+1], rx_q[4*i+2], rx_q[4*i+3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    cpu_done = 1'b0;
    ev       = '0;
    rstn     = 1'b0;
    repeat (3) tick();
    rx_q.delete();
    rstn = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n [8];
    int lo, hi, w;

    rstn = 1'b0; ev = '0; cpu_done = 1'b0;

    // Reset with events toggling: line must stay idle.
    repeat (10) begin tick(); ev = 8'($urandom); end
    ev = '0;
    rstn = 1'b1;
    repeat (5) tick();
    check("reset_no_uart", 64'(rx_q.size()), 64'd0);
    for (int i = 0; i < 8; i++) check("model_reset_cnt", 64'(mcnt[i]), 64'd0);

    // Single event: 10 edges of read_C_L1I.
    ev[0] = 1'b1;
    repeat (10) tick();
    ev[0] = 1'b0;
    cpu_done = 1'b1;
    w = 0; lo = 0; hi = 0;
    while (tx_data !== 1'b0 && w < 10) begin @(negedge clk); w++; end
    check("start_within_2", 64'(w < 10), 64'd1);
    while (tx_data === 1'b0 && lo < 2000) begin @(negedge clk); lo++; end
    while (tx_data === 1'b1 && hi < 200) begin @(negedge clk); hi++; end
    check("frame0_low_len", 64'(lo), 64'(9 * C));
    check("frame0_stop_len", 64'(hi), 64'(C));
    repeat (NB * 10 * C) tick();
    check("model_single_cnt", 64'(mcnt[0]), 64'd10);
    check("single_nbytes", 64'(rx_q.size()), 64'(NB));
    check("single_b0", 64'(rx_word(0) >> 24), 64'h00);
    check("single_b3", 64'(rx_word(0) & 32'hFF), 64'h0A);
    for (int i = 1; i < 8; i++) check("single_zero_word", 64'(rx_word(i)), 64'd0);
    // No second dump after cpu_done is dropped and re-asserted.
    cpu_done = 1'b0;
    repeat (20) tick();
    cpu_done = 1'b1;
    repeat (300) tick();
    check("no_redump", 64'(rx_q.size()), 64'(NB));

    // Mixed workload with events concurrent with and after cpu_done.
    do_reset();
    n = '{100, 20, 30, 20, 50, 20, 20, 0};
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < 8; i++) ev[i] = (k < n[i]);
      tick();
    end
    ev = '1;
    cpu_done = 1'b1;
    repeat (50) tick();
    repeat (NB * 10 * C + 20) begin tick(); ev = 8'($urandom); end
    ev = '0;
    check("mixed_nbytes", 64'(rx_q.size()), 64'(NB));
    for (int i = 0; i < 8; i++) check("mixed_word", 64'(rx_word(i)), 64'(n[i]));

    // Reset during byte 5 of a dump.
    do_reset();
    ev[2] = 1'b1;
    repeat (5) tick();
    ev[2] = 1'b0;
    cpu_done = 1'b1;
    repeat (2 + 5 * 10 * C + 3 * C) tick();
    rstn = 1'b0;
    #1;
    check("abort_tx_high", {63'd0, tx_data}, 64'd1);
    check("abort_bytes_seen", 64'(rx_q.size()), 64'd5);
    do_reset();
    for (int k = 0; k < 7; k++) begin
      ev[7] = 1'b1;
      ev[0] = (k < 3);
      tick();
    end
    ev = '0;
    cpu_done = 1'b1;
    repeat (NB * 10 * C + 20) tick();
    check("redump_nbytes", 64'(rx_q.size()), 64'(NB));
    check("redump_w0", 64'(rx_word(0)), 64'd3);
    check("redump_w2", 64'(rx_word(2)), 64'd0);
    check("redump_w7", 64'(rx_word(7)), 64'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
